systolic_pe: RTL and testbench
==============================

SYSTOLIC_PE -- requirements
Module: systolic_pe

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning the operand width in bits.
REQ-002 The module SHALL have parameter ACC_W, default 32, meaning the accumulator width in bits; ACC_W >= 2*DATA_W.
REQ-003 The module SHALL have parameter SIGNED, default 0, meaning 0 = unsigned operands and 1 = two's-complement operands.
REQ-004 The module SHALL have parameter SATURATE, default 1, meaning 1 = clamp the accumulator at its limits and 0 = wrap modulo 2^ACC_W.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 The module SHALL have port en, input, 1 bit: global enable; low freezes all state.
REQ-008 The module SHALL have ports a_in / b_in, input, DATA_W bits each: west and north operands.
REQ-009 The module SHALL have ports a_vld_in / b_vld_in, input, 1 bit each: operand valid qualifiers.
REQ-010 The module SHALL have port last_in, input, 1 bit, which travels with a_in and marks the final term of a dot product.
REQ-011 The module SHALL have ports a_out / b_out, output, DATA_W bits each: the registered operands passed east and south.
REQ-012 The module SHALL have ports a_vld_out / b_vld_out / last_out, output, 1 bit each: the registered qualifiers passed on.
REQ-013 The module SHALL have port c_out, output, ACC_W bits: the completed dot-product result.
REQ-014 The module SHALL have port c_vld, output, 1 bit: a one-cycle pulse that qualifies c_out.
REQ-015 The module SHALL have port ovf, output, 1 bit: the overflow/saturation flag for the result on c_out, valid with c_vld.

Function
REQ-016 Stage 1 SHALL register a_in, b_in, a_vld_in, b_vld_in and last_in; a_out, b_out and the qualifier outputs SHALL equal these stage-1 registers, giving a pass-through latency of 1 cycle.
REQ-017 Stage 2 SHALL register the full-precision product (2*DATA_W bits, signed or unsigned per SIGNED) with prod_vld = a_vld & b_vld and the delayed last flag.
REQ-018 When either stage-1 operand is zero, or prod_vld is 0, the product register SHALL NOT toggle (zero-gating) and the product SHALL be treated as 0.
REQ-019 Stage 3 SHALL sign- or zero-extend the product to ACC_W bits and add it to the accumulator when prod_vld is 1.
REQ-020 Operand-in to c_vld latency SHALL be 3 enabled cycles, measured from the term carrying last_in.
REQ-021 The state machine SHALL have two states: IDLE (accumulator 0, no term received) and ACC (at least one term received).
REQ-022 IDLE SHALL transition to ACC on prod_vld without the last flag.
REQ-023 ACC SHALL remain in ACC on prod_vld without the last flag.
REQ-024 Either state SHALL go to IDLE when the last flag reaches stage 3.
REQ-025 When the last flag reaches stage 3, the block SHALL set c_out to acc + product (the product is included if valid, and is 0 otherwise), pulse c_vld, set ovf to the sticky flag OR this cycle's overflow, clear the accumulator and the sticky flag to 0, and enter IDLE.
REQ-026 A last flag arriving with prod_vld = 0 SHALL still flush and emit, so a last-only term emits the current accumulator.
REQ-027 Back-to-back dot products SHALL be supported: a term arriving in the cycle after a last term SHALL start the new sum from 0 with no bubble.
REQ-028 With SATURATE = 1, the accumulator SHALL clamp at the maximum or minimum of the ACC_W-bit range and set the sticky overflow flag.
REQ-029 With SATURATE = 0, the accumulator SHALL wrap and still set the sticky overflow flag on a carry-out (unsigned) or a sign overflow (signed).
REQ-030 While en = 0, all registers SHALL hold, c_vld SHALL be 0 and c_out SHALL hold its value; on resuming, the pipeline SHALL continue exactly where it stopped.
REQ-031 c_out SHALL hold its last result until the next c_vld.

Reset
REQ-032 When rst_n = 0 at a clock edge, all pipeline registers, a_out, b_out, every valid output, last_out, c_out, c_vld, ovf, the accumulator and the sticky flag SHALL be set to 0, and the state SHALL be set to IDLE.
REQ-033 Reset SHALL take priority over en.
REQ-034 Reset during accumulation SHALL discard the partial sum with no c_vld.

Structure
REQ-035 Package pe_pkg SHALL hold the state enum (IDLE, ACC) and the saturation-limit helper functions parameterised by ACC_W and signedness.
REQ-036 Sub-module pe_sat_add SHALL implement the ACC_W-bit add with the SATURATE/SIGNED modes and an overflow output; all other logic SHALL stay in systolic_pe.

Verification
REQ-037 Unsigned default: drive terms (3,4), (5,6), then (2,7) with last -> single c_vld with c_out = 56 and ovf = 0, 3 cycles after the last term; a_out and b_out follow each input by 1 cycle.
REQ-038 SIGNED=1: drive (-3,4) then (-128,-128) with last -> c_out = 16372 (-12 + 16384), ovf = 0.
REQ-039 ACC_W=16, SATURATE=1, unsigned: drive five terms of (255,255) with last on the fifth -> c_out = 65535, ovf = 1; the next dot product of (1,1) with last -> c_out = 1, ovf = 0.
REQ-040 Back-to-back with a stall: drive (2,2) with last, then (3,3) with last, with en held low for 2 cycles between them -> c_out = 4 then 9, one c_vld each, no c_vld while en is low.
REQ-041 Zero and invalid terms: drive (0,9), (7,7) with b_vld = 0, then a last-only term -> c_out = 0, c_vld = 1, and the product register does not toggle.
REQ-042 Reset mid-sum: drive (10,10), assert rst_n low for 1 cycle, then drive (1,2) with last -> only one c_vld, with c_out = 2.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants and helpers for the systolic processing element.
package pe_pkg;

   // Accumulation state encoding
   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_ACC  = 1'b1;

   // Largest value representable in a w-bit accumulator (w <= 64), as a 64-bit pattern
   function automatic logic [63:0] sat_max(input int w, input bit sgn);
      if (sgn)
         return (64'd1 << (w - 1)) - 64'd1;
      else if (w >= 64)
         return '1;
      else
         return (64'd1 << w) - 64'd1;
   endfunction

   // Smallest value representable in a w-bit accumulator; callers truncate to w bits
   function automatic logic [63:0] sat_min(input int w, input bit sgn);
      if (sgn)
         return ~((64'd1 << (w - 1)) - 64'd1);
      else
         return '0;
   endfunction

endpackage

// File: rtl/pe_sat_add.sv
// ACC_W-bit adder with optional clamping and an overflow indication.
module pe_sat_add
   import pe_pkg::*;
#(
   parameter int ACC_W    = 32,
   parameter int SIGNED   = 0,
   parameter int SATURATE = 1
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             ovf
);

   localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W, SIGNED != 0));
   localparam logic [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W, SIGNED != 0));

   logic [ACC_W:0] raw;

   // Add, detect carry-out or sign overflow, then clamp or wrap
   always_comb begin
      raw = {1'b0, a} + {1'b0, b};
      if (SIGNED != 0)
         ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
      else
         ovf = raw[ACC_W];
      sum = raw[ACC_W-1:0];
      if (ovf && (SATURATE != 0)) begin
         if ((SIGNED != 0) && a[ACC_W-1])
            sum = MIN_V;
         else
            sum = MAX_V;
      end
   end

endmodule

// File: rtl/systolic_pe.sv
// Systolic-array processing element: operand pass-through, zero-gated
// multiply and a flushing accumulator that emits one dot product per last term.
//
//   state   | meaning
//   --------+---------------------------------------------
//   ST_IDLE | accumulator is 0, no term of a sum received
//   ST_ACC  | at least one term of the current sum received
module systolic_pe
   import pe_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 32,
   parameter int SIGNED   = 0,
   parameter int SATURATE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic              a_vld_in,
   input  logic              b_vld_in,
   input  logic              last_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic              a_vld_out,
   output logic              b_vld_out,
   output logic              last_out,
   output logic [ACC_W-1:0]  c_out,
   output logic              c_vld,
   output logic              ovf
);

   localparam int PW = 2 * DATA_W;

   logic [DATA_W-1:0] a_r, b_r;
   logic              av_r, bv_r, last_r;
   logic [PW-1:0]     a_ext, b_ext, prod_full, prod_r;
   logic              pv_r, nz_r, last2_r, gate;
   logic [ACC_W-1:0]  prod_ext, addend, base, acc_r, sum;
   logic              add_ovf, sticky_r, state_r;
   logic [ACC_W-1:0]  c_out_r;
   logic              c_vld_r, ovf_r;

   assign a_out     = a_r;
   assign b_out     = b_r;
   assign a_vld_out = av_r;
   assign b_vld_out = bv_r;
   assign last_out  = last_r;
   assign c_out     = c_out_r;
   assign c_vld     = c_vld_r;
   assign ovf       = ovf_r;

   // Stage 1: capture operands and qualifiers for the neighbours
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_r    <= '0;
         b_r    <= '0;
         av_r   <= 1'b0;
         bv_r   <= 1'b0;
         last_r <= 1'b0;
      end else if (en) begin
         a_r    <= a_in;
         b_r    <= b_in;
         av_r   <= a_vld_in;
         bv_r   <= b_vld_in;
         last_r <= last_in;
      end
   end

   // Full-precision product; both operands widened so one multiplier serves both modes
   always_comb begin
      if (SIGNED != 0) begin
         a_ext = {{DATA_W{a_r[DATA_W-1]}}, a_r};
         b_ext = {{DATA_W{b_r[DATA_W-1]}}, b_r};
      end else begin
         a_ext = {{DATA_W{1'b0}}, a_r};
         b_ext = {{DATA_W{1'b0}}, b_r};
      end
      prod_full = a_ext * b_ext;
      gate      = av_r && bv_r && (a_r != '0) && (b_r != '0);
   end

   // Stage 2: product register only loads for a valid non-zero term
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prod_r  <= '0;
         pv_r    <= 1'b0;
         nz_r    <= 1'b0;
         last2_r <= 1'b0;
      end else if (en) begin
         pv_r    <= av_r & bv_r;
         nz_r    <= gate;
         last2_r <= last_r;
         if (gate)
            prod_r <= prod_full;
      end
   end

   generate
      if (ACC_W > PW) begin : g_ext
         assign prod_ext = {{(ACC_W - PW){(SIGNED != 0) ? prod_r[PW-1] : 1'b0}}, prod_r};
      end else begin : g_noext
         assign prod_ext = prod_r;
      end
   endgenerate

   assign addend = nz_r ? prod_ext : '0;
   assign base   = (state_r == ST_ACC) ? acc_r : '0;

   pe_sat_add #(
      .ACC_W    (ACC_W),
      .SIGNED   (SIGNED),
      .SATURATE (SATURATE)
   ) u_add (
      .a   (base),
      .b   (addend),
      .sum (sum),
      .ovf (add_ovf)
   );

   // Stage 3: accumulate, or flush and emit the result when the last flag arrives
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_r    <= '0;
         sticky_r <= 1'b0;
         state_r  <= ST_IDLE;
         c_out_r  <= '0;
         c_vld_r  <= 1'b0;
         ovf_r    <= 1'b0;
      end else if (en) begin
         c_vld_r <= 1'b0;
         if (last2_r) begin
            c_out_r  <= sum;
            c_vld_r  <= 1'b1;
            ovf_r    <= sticky_r | add_ovf;
            acc_r    <= '0;
            sticky_r <= 1'b0;
            state_r  <= ST_IDLE;
         end else if (pv_r) begin
            acc_r    <= sum;
            sticky_r <= sticky_r | add_ovf;
            state_r  <= ST_ACC;
         end
      end else begin
         c_vld_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_systolic_pe.sv
// Bench for systolic_pe: four configurations share one stimulus stream and are
// checked against an arithmetic model of the dot-product rules.
module tb_systolic_pe;

   logic       clk = 1'b0;
   logic       rst_n, en, a_vld_in, b_vld_in, last_in;
   logic [7:0] a_in, b_in;

   logic [7:0]  a_o [4];
   logic [7:0]  b_o [4];
   logic        av_o [4];
   logic        bv_o [4];
   logic        l_o [4];
   logic        cv [4];
   logic        ov [4];
   logic [31:0] c0, c1;
   logic [15:0] c2, c3;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   systolic_pe #(.DATA_W(8), .ACC_W(32), .SIGNED(0), .SATURATE(1)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in), .b_in(b_in),
      .a_vld_in(a_vld_in), .b_vld_in(b_vld_in), .last_in(last_in),
      .a_out(a_o[0]), .b_out(b_o[0]), .a_vld_out(av_o[0]), .b_vld_out(bv_o[0]),
      .last_out(l_o[0]), .c_out(c0), .c_vld(cv[0]), .ovf(ov[0]));

   systolic_pe #(.DATA_W(8), .ACC_W(32), .SIGNED(1), .SATURATE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in), .b_in(b_in),
      .a_vld_in(a_vld_in), .b_vld_in(b_vld_in), .last_in(last_in),
      .a_out(a_o[1]), .b_out(b_o[1]), .a_vld_out(av_o[1]), .b_vld_out(bv_o[1]),
      .last_out(l_o[1]), .c_out(c1), .c_vld(cv[1]), .ovf(ov[1]));

   systolic_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(1)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in), .b_in(b_in),
      .a_vld_in(a_vld_in), .b_vld_in(b_vld_in), .last_in(last_in),
      .a_out(a_o[2]), .b_out(b_o[2]), .a_vld_out(av_o[2]), .b_vld_out(bv_o[2]),
      .last_out(l_o[2]), .c_out(c2), .c_vld(cv[2]), .ovf(ov[2]));

   systolic_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0)) u3 (
      .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in), .b_in(b_in),
      .a_vld_in(a_vld_in), .b_vld_in(b_vld_in), .last_in(last_in),
      .a_out(a_o[3]), .b_out(b_o[3]), .a_vld_out(av_o[3]), .b_vld_out(bv_o[3]),
      .last_out(l_o[3]), .c_out(c3), .c_vld(cv[3]), .ovf(ov[3]));

   function automatic int cw(input int i);
      return (i < 2) ? 32 : 16;
   endfunction

   function automatic bit csg(input int i);
      return (i == 1) || (i == 3);
   endfunction

   function automatic bit cst(input int i);
      return (i != 3);
   endfunction

   function automatic logic [63:0] cobs(input int i);
      case (i)
         0:       return {32'b0, c0};
         1:       return {32'b0, c1};
         2:       return {48'b0, c2};
         default: return {48'b0, c3};
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      int               cnt;
      logic [3:0][31:0] val;
      logic [3:0]       ov;
   } pend_t;

   pend_t            pq[$];
   longint           acc_m [4];
   bit               stk_m [4];
   logic [3:0][31:0] exp_c;
   logic [3:0]       exp_ov;
   logic             exp_vld;
   logic [7:0]       exp_a, exp_b;
   logic             exp_av, exp_bv, exp_l;

   task automatic step(input logic [7:0] a, input logic [7:0] b, input bit av, input bit bv,
                       input bit lst, input bit e, input bit r);
      pend_t  t;
      longint p, s, mx, mn, md;
      bit     of;
      a_in = a; b_in = b; a_vld_in = av; b_vld_in = bv; last_in = lst;
      en = e; rst_n = ~r;
      @(posedge clk);
      exp_vld = 1'b0;
      if (r) begin
         pq.delete();
         for (int i = 0; i < 4; i++) begin
            acc_m[i] = 0;
            stk_m[i] = 1'b0;
         end
         exp_c = '0;
         exp_a = '0; exp_b = '0; exp_av = 1'b0; exp_bv = 1'b0; exp_l = 1'b0;
      end else if (e) begin
         exp_a = a; exp_b = b; exp_av = av; exp_bv = bv; exp_l = lst;
         for (int k = 0; k < pq.size(); k++) begin
            t = pq[k];
            t.cnt--;
            pq[k] = t;
         end
         if (pq.size() > 0 && pq[0].cnt == 0) begin
            t = pq.pop_front();
            exp_vld = 1'b1;
            exp_c   = t.val;
            exp_ov  = t.ov;
         end
         t = '0;
         t.cnt = 2;
         for (int i = 0; i < 4; i++) begin
            md = longint'(1) << cw(i);
            if (csg(i)) begin
               mx = (longint'(1) << (cw(i) - 1)) - 1;
               mn = -(longint'(1) << (cw(i) - 1));
            end else begin
               mx = md - 1;
               mn = 0;
            end
            if (av && bv)
               p = csg(i) ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
            else
               p = 0;
            s  = acc_m[i] + p;
            of = (s > mx) || (s < mn);
            if (of) begin
               if (cst(i))
                  s = (s > mx) ? mx : mn;
               else begin
                  s = s & (md - 1);
                  if (csg(i) && s > mx)
                     s = s - md;
               end
            end
            acc_m[i] = s;
            stk_m[i] = stk_m[i] | of;
            if (lst) begin
               t.val[i] = 32'(s & (md - 1));
               t.ov[i]  = stk_m[i];
               acc_m[i] = 0;
               stk_m[i] = 1'b0;
            end
         end
         if (lst)
            pq.push_back(t);
      end
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("c_vld[%0d]", i), cv[i], exp_vld);
         chk($sformatf("c_out[%0d]", i), cobs(i), exp_c[i]);
         if (exp_vld)
            chk($sformatf("ovf[%0d]", i), ov[i], exp_ov[i]);
         chk($sformatf("a_out[%0d]", i), a_o[i], exp_a);
         chk($sformatf("b_out[%0d]", i), b_o[i], exp_b);
         chk($sformatf("a_vld_out[%0d]", i), av_o[i], exp_av);
         chk($sformatf("b_vld_out[%0d]", i), bv_o[i], exp_bv);
         chk($sformatf("last_out[%0d]", i), l_o[i], exp_l);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [7:0]  a, b;
      bit          av, bv, lst, en;
      int          sel;
      bit          vld;
      logic [31:0] c;
      bit          ov;
   } vec_t;

   function automatic vec_t mk(input int a, input int b, input bit av, input bit bv,
                               input bit lst, input bit e, input int sel,
                               input bit vld, input int c, input bit o);
      vec_t v;
      v.a = 8'(a); v.b = 8'(b); v.av = av; v.bv = bv; v.lst = lst; v.en = e;
      v.sel = sel; v.vld = vld; v.c = 32'(c); v.ov = o;
      return v;
   endfunction

   vec_t tv [25];

   initial begin
      int pulses;
      logic [7:0] ra, rb;

      tv[0]  = mk(3, 4, 1, 1, 0, 1, 0, 0, 0, 0);
      tv[1]  = mk(5, 6, 1, 1, 0, 1, 0, 0, 0, 0);
      tv[2]  = mk(2, 7, 1, 1, 1, 1, 0, 0, 0, 0);
      tv[3]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tv[4]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 56, 0);
      tv[5]  = mk(253, 4, 1, 1, 0, 1, 1, 0, 0, 0);
      tv[6]  = mk(128, 128, 1, 1, 1, 1, 1, 0, 0, 0);
      tv[7]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      tv[8]  = mk(0, 0, 0, 0, 0, 1, 1, 1, 16372, 0);
      tv[9]  = mk(255, 255, 1, 1, 0, 1, 2, 0, 0, 0);
      tv[10] = mk(255, 255, 1, 1, 0, 1, 2, 0, 0, 0);
      tv[11] = mk(255, 255, 1, 1, 0, 1, 2, 0, 0, 0);
      tv[12] = mk(255, 255, 1, 1, 0, 1, 2, 0, 0, 0);
      tv[13] = mk(255, 255, 1, 1, 1, 1, 2, 0, 0, 0);
      tv[14] = mk(0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
      tv[15] = mk(0, 0, 0, 0, 0, 1, 2, 1, 65535, 1);
      tv[16] = mk(1, 1, 1, 1, 1, 1, 2, 0, 0, 0);
      tv[17] = mk(0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
      tv[18] = mk(0, 0, 0, 0, 0, 1, 2, 1, 1, 0);
      tv[19] = mk(2, 2, 1, 1, 1, 1, 0, 0, 0, 0);
      tv[20] = mk(9, 9, 1, 1, 1, 0, 0, 0, 0, 0);
      tv[21] = mk(9, 9, 1, 1, 1, 0, 0, 0, 0, 0);
      tv[22] = mk(3, 3, 1, 1, 1, 1, 0, 0, 0, 0);
      tv[23] = mk(0, 0, 0, 0, 0, 1, 0, 1, 4, 0);
      tv[24] = mk(0, 0, 0, 0, 0, 1, 0, 1, 9, 0);

      // reset, including reset asserted while en is low
      step(8'd0, 8'd0, 0, 0, 0, 1, 1);
      step(8'd0, 8'd0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++)
         chk($sformatf("rst_ovf[%0d]", i), ov[i], 1'b0);

      for (int k = 0; k < 25; k++) begin
         step(tv[k].a, tv[k].b, tv[k].av, tv[k].bv, tv[k].lst, tv[k].en, 0);
         chk($sformatf("tbl%0d_vld", k), cv[tv[k].sel], tv[k].vld);
         if (tv[k].vld) begin
            chk($sformatf("tbl%0d_c", k), cobs(tv[k].sel), {32'b0, tv[k].c});
            chk($sformatf("tbl%0d_ovf", k), ov[tv[k].sel], tv[k].ov);
         end
      end

      // zero operand, invalid operand, then a last-only flush
      step(8'd0, 8'd9, 1, 1, 0, 1, 0);
      chk("zg_prod0", u0.prod_r, 64'd9);
      step(8'd7, 8'd7, 1, 0, 0, 1, 0);
      chk("zg_prod1", u0.prod_r, 64'd9);
      step(8'd0, 8'd0, 0, 0, 1, 1, 0);
      chk("zg_prod2", u0.prod_r, 64'd9);
      step(8'd0, 8'd0, 0, 0, 0, 1, 0);
      chk("zg_prod3", u0.prod_r, 64'd9);
      step(8'd0, 8'd0, 0, 0, 0, 1, 0);
      chk("zg_vld", cv[0], 1'b1);
      chk("zg_c", cobs(0), 64'd0);
      chk("zg_prod4", u0.prod_r, 64'd9);

      // reset in the middle of a sum discards it
      pulses = 0;
      step(8'd10, 8'd10, 1, 1, 0, 1, 0);
      pulses += int'(cv[0]);
      step(8'd0, 8'd0, 0, 0, 0, 1, 1);
      pulses += int'(cv[0]);
      step(8'd1, 8'd2, 1, 1, 1, 1, 0);
      pulses += int'(cv[0]);
      for (int k = 0; k < 3; k++) begin
         step(8'd0, 8'd0, 0, 0, 0, 1, 0);
         pulses += int'(cv[0]);
      end
      chk("rst_mid_pulses", 64'(pulses), 64'd1);
      chk("rst_mid_c", cobs(0), 64'd2);

      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         case ($urandom_range(0, 7))
            0:       ra = 8'd0;
            1:       ra = 8'd255;
            2:       ra = 8'd128;
            default: ra = 8'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0:       rb = 8'd0;
            1:       rb = 8'd255;
            2:       rb = 8'd127;
            default: rb = 8'($urandom);
         endcase
         step(ra, rb, ($urandom % 8) != 0, ($urandom % 8) != 0, ($urandom % 5) == 0,
              ($urandom % 10) != 0, ($urandom % 150) == 0);
      end
      for (int k = 0; k < 4; k++)
         step(8'd0, 8'd0, 0, 0, 0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
